// File: rtl/mult32x32_client.sv
// mult32x32_client: request-side initiator for the 32x32 sequential multiplier.
// Queues operand pairs from an upstream valid/ready stream, issues them one at
// a time to the multiplier (start pulse, wait for busy to drop), and returns
// each 64-bit product on a downstream valid/ready stream.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_valid/in_ready/in_a/in_b     upstream operand-pair stream
//   out_valid/out_ready/out_product downstream product stream
//   mul_start/mul_a/mul_b           request to the multiplier
//   mul_busy/mul_product            response from the multiplier
//   err                             sticky busy-watchdog error
//   done_cnt                        products handed off (wraps at 2^16)
module mult32x32_client #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_busy,
  input  logic [63:0] mul_product,
  output logic        err,
  output logic [15:0] done_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_next;

  logic push;
  logic pop;
  logic capture;
  logic handoff;
  logic err_set;

  // Handshake/strobe outputs decoded from registered state and count only.
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign mul_start = (state == S_ISSUE);
  assign out_valid = (state == S_RESP);

  // Operand storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    handoff    = 1'b0;
    err_set    = 1'b0;
    wd_next    = wd_cnt;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_next    = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        wd_next = wd_cnt + WW'(1);
        // The multiplier clears its product one edge after busy drops,
        // so capture must happen on the very first not-busy cycle.
        if (!mul_busy) begin
          capture    = 1'b1;
          state_next = S_RESP;
        end else if (wd_next == WW'(TIMEOUT)) begin
          err_set    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          handoff    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands change only on pop in IDLE, so they are stable while in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a       <= '0;
      mul_b       <= '0;
      out_product <= '0;
      err         <= 1'b0;
      done_cnt    <= '0;
      wd_cnt      <= '0;
    end else begin
      wd_cnt <= wd_next;
      if (pop) begin
        mul_a <= mem[rd_ptr].a;
        mul_b <= mem[rd_ptr].b;
      end
      if (capture) out_product <= mul_product;
      if (err_set) err <= 1'b1;
      if (handoff) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult32x32_client.sv
// Self-checking bench for mult32x32_client with a behavioural multiplier
// (4 busy cycles after the start edge, product valid for one cycle).
module tb_mult32x32_client;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_busy;
  logic [63:0] mul_product;
  logic        err;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  mult32x32_client #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_busy    (mul_busy),
    .mul_product (mul_product),
    .err         (err),
    .done_cnt    (done_cnt)
  );

  // Multiplier model: busy from the cycle after start, product clears one
  // edge after busy drops; hold_busy keeps it busy indefinitely.
  logic       hold_busy;
  logic [1:0] m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy    <= 1'b0;
      m_cnt       <= 2'd0;
      mul_product <= 64'd0;
    end else if (mul_start) begin
      mul_busy    <= 1'b1;
      m_cnt       <= 2'd0;
      mul_product <= 64'd0;
    end else if (mul_busy) begin
      if (!hold_busy) begin
        if (m_cnt == 2'd3) begin
          mul_busy    <= 1'b0;
          mul_product <= {32'd0, mul_a} * {32'd0, mul_b};
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
    end else begin
      mul_product <= 64'd0;
    end
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Protocol watcher: operands stable while busy, no back-to-back starts.
  bit          stab_bad = 1'b0;
  bit          double_start = 1'b0;
  bit          prev_start = 1'b0;
  bit          inflight = 1'b0;
  int          wait_seen = 0;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  always @(negedge clk) begin
    if (reset) begin
      inflight   = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (mul_start && prev_start) double_start = 1'b1;
      prev_start = mul_start;
      if (mul_start) begin
        lat_a    = mul_a;
        lat_b    = mul_b;
        inflight = 1'b1;
      end else if (inflight && mul_busy) begin
        wait_seen++;
        if (mul_a !== lat_a || mul_b !== lat_b) stab_bad = 1'b1;
      end else begin
        inflight = 1'b0;
      end
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb[$];
  longint      out_cycs[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge: on a handshake, compare against the scoreboard head.
  task automatic sample_out(input string tag);
    if (out_valid && out_ready) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk(tag, out_product, sb.pop_front());
      out_cycs.push_back(cyc);
    end
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit track);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    if (track) sb.push_back(64'(a) * 64'(b));
  endtask

  task automatic wait_product(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    sample_out(tag);
    tick();
  endtask

  task automatic drain(input string tag, input int k);
    int n = 0;
    int start = out_cycs.size();
    while (out_cycs.size() - start < k && n < 400) begin
      @(negedge clk);
      sample_out(tag);
      tick();
      n++;
    end
    chk({tag, "_count"}, 64'(out_cycs.size() - start), 64'(k));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit          acc;
    bit          seen_full;
    int          i;
    int          j;
    logic [63:0] held;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Single pair: latency and one-cycle start pulse.
    out_ready = 1'b1;
    push_pair(32'h3, 32'h5, 1'b1);
    @(negedge clk); chk("t1_start_c1", 64'(mul_start), 64'd0);
    @(negedge clk); chk("t1_start_c2", 64'(mul_start), 64'd1);
    @(negedge clk); chk("t1_start_c3", 64'(mul_start), 64'd0);
    repeat (3) @(negedge clk);
    @(negedge clk); chk("t1_valid_c7", 64'(out_valid), 64'd0);
    @(negedge clk); chk("t1_valid_c8", 64'(out_valid), 64'd1);
    chk("t1_prod_lit", out_product, 64'h0000_0000_0000_000F);
    sample_out("t1_prod");
    tick();
    @(negedge clk);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_valid_c9", 64'(out_valid), 64'd0);
    tick();

    // Full-width operands.
    push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_product("t2a");
    chk("t2a_lit", out_product, 64'hFFFF_FFFE_0000_0001);
    push_pair(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_product("t2b");
    chk("t2b_lit", out_product, 64'h0B00_EA4E_242D_2080);
    chk("t2_operand_stable", 64'(stab_bad), 64'd0);
    chk("t2_wait_observed", 64'(wait_seen != 0), 64'd1);
    chk("t2_done", 64'(done_cnt), 64'd3);

    // Burst of 6 pairs into a 4-deep FIFO.
    out_cycs.delete();
    seen_full = 1'b0;
    i = 0;
    for (int n = 0; n < 60 && i < 6; n++) begin
      in_valid = 1'b1;
      in_a = 32'(i + 1);
      in_b = 32'd2;
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) seen_full = 1'b1;
      sample_out("t3");
      tick();
      if (acc) begin
        sb.push_back(64'(i + 1) * 64'd2);
        i++;
      end
    end
    in_valid = 1'b0;
    chk("t3_all_accepted", 64'(i), 64'd6);
    chk("t3_full_seen", 64'(seen_full), 64'd1);
    drain("t3", 6 - out_cycs.size());
    for (int k = 1; k < 6; k++) begin
      if (k < out_cycs.size()) chk("t3_gap", 64'(out_cycs[k] - out_cycs[k-1]), 64'd8);
    end
    chk("t3_done", 64'(done_cnt), 64'd9);
    chk("t3_in_ready", 64'(in_ready), 64'd1);

    // Downstream backpressure for 20 cycles.
    out_ready = 1'b0;
    push_pair(32'h11, 32'h22, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_pending", 64'(out_valid), 64'd1);
    chk("t4_prod_lit", out_product, 64'h242);
    held = out_product;
    tick();
    j = 0;
    for (int c = 0; c < 20; c++) begin
      if (j < 4) begin
        in_valid = 1'b1;
        in_a = 32'h100 + 32'(j);
        in_b = 32'd3;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("t4_valid_held", 64'(out_valid), 64'd1);
      chk("t4_product_held", out_product, held);
      chk("t4_no_start", 64'(mul_start), 64'd0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sb.push_back(64'(32'h100 + 32'(j)) * 64'd3);
        j++;
      end
    end
    in_valid = 1'b0;
    chk("t4_queued", 64'(j), 64'd4);
    chk("t4_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk); sample_out("t4_first");
    tick();
    @(negedge clk); chk("t4_start_r1", 64'(mul_start), 64'd0);
    tick();
    @(negedge clk); chk("t4_start_r2", 64'(mul_start), 64'd1);
    chk("t4_slot_freed", 64'(in_ready), 64'd1);
    tick();
    drain("t4", 4);
    chk("t4_done", 64'(done_cnt), 64'd14);

    // Busy watchdog.
    hold_busy = 1'b1;
    push_pair(32'h7, 32'h7, 1'b0);
    repeat (17) begin
      @(negedge clk);
      chk("t5_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    @(negedge clk); chk("t5_err_c18", 64'(err), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_err_c19", 64'(err), 64'd1);
    chk("t5_no_valid_c19", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk); chk("t5_idle_no_start", 64'(mul_start), 64'd0);
    tick();
    hold_busy = 1'b0;
    repeat (10) tick();
    push_pair(32'h7, 32'h6, 1'b1);
    wait_product("t5_after");
    chk("t5_after_lit", out_product, 64'd42);
    chk("t5_err_sticky", 64'(err), 64'd1);
    chk("t5_done", 64'(done_cnt), 64'd15);

    // Asynchronous reset during WAIT with 3 entries queued.
    i = 0;
    for (int n = 0; n < 20 && i < 4; n++) begin
      in_valid = 1'b1;
      in_a = 32'h20 + 32'(i);
      in_b = 32'd5;
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) i++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_wait", 64'(mul_busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_mul_start", 64'(mul_start), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    push_pair(32'hDEAD_BEEF, 32'h10, 1'b1);
    wait_product("t6_after");
    chk("t6_after_lit", out_product, 64'h0000_000D_EADB_EEF0);
    chk("t6_done", 64'(done_cnt), 64'd1);
    chk("t6_err_clear", 64'(err), 64'd0);

    repeat (4) tick();
    chk("end_operand_stable", 64'(stab_bad), 64'd0);
    chk("end_no_double_start", 64'(double_start), 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
